// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: modulus, enable, clamped parallel load, wrap/saturate mode.
// Define UPDOWN_CNT_OVF_STICKY_EN to add the sticky overflow flag (ovf_clr / ovf_flag).
module updown_counter_param #(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 16,
  parameter longint RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic             UpOrDown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
`ifdef UPDOWN_CNT_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_flag,
`endif
  output logic [WIDTH-1:0] Count,
  output logic             tc,
  output logic             wrap_evt
);

  // One extra bit so MODULUS = 2^WIDTH is representable for the load clamp compare
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'sd1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_top_s, at_bot_s;

  assign at_top_s = (count_q == MAX_VAL);
  assign at_bot_s = (count_q == ZERO);

  // Next-state selection: load beats count; bounds are tested before any +/-1
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        count_d = load_val;
      end else begin
        count_d = MAX_VAL;
      end
    end else if (en) begin
      if (UpOrDown) begin
        if (!at_top_s) begin
          count_d = count_q + ONE;
        end else if (!sat_mode) begin
          count_d = ZERO;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q;
        end
      end else begin
        if (!at_bot_s) begin
          count_d = count_q - ONE;
        end else if (!sat_mode) begin
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count and wrap pulse registers, synchronous reset has top priority
  always_ff @(posedge Clk) begin
    if (reset) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Count    = count_q;
  assign wrap_evt = wrap_q;
  assign tc       = !reset && (UpOrDown ? at_top_s : at_bot_s);

`ifdef UPDOWN_CNT_OVF_STICKY_EN
  logic ovf_q, ovf_d, ovf_hit_s;

  // A bound hit counts whether it wraps or saturates; a load on the same edge suppresses it
  assign ovf_hit_s = en && !load && (UpOrDown ? at_top_s : at_bot_s);

  // Sticky set dominates a same-edge clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_hit_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sticky overflow register
  always_ff @(posedge Clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_flag = ovf_q;
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed table-driven bench for updown_counter_param (WIDTH=4, MODULUS=10, RESET_VAL=0).
module tb_updown_counter_param;

  logic       Clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, UpOrDown = 1'b0, load = 1'b0, sat_mode = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] Count;
  logic       tc, wrap_evt;
`ifdef UPDOWN_CNT_OVF_STICKY_EN
  logic       ovf_clr = 1'b0;
  logic       ovf_flag;
`endif

  int errors = 0;
  int checks = 0;

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .en       (en),
    .UpOrDown (UpOrDown),
    .load     (load),
    .load_val (load_val),
    .sat_mode (sat_mode),
`ifdef UPDOWN_CNT_OVF_STICKY_EN
    .ovf_clr  (ovf_clr),
    .ovf_flag (ovf_flag),
`endif
    .Count    (Count),
    .tc       (tc),
    .wrap_evt (wrap_evt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst, en, up, ld;
    logic [3:0] lv;
    logic       sat;
    logic [3:0] exp_cnt;
    logic       exp_wrap, exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] lv, input logic s,
                     input logic [3:0] c, input logic w, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.ld = l; v.lv = lv; v.sat = s;
    v.exp_cnt = c; v.exp_wrap = w; v.exp_tc = t;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input logic s);
    reset = r; en = e; UpOrDown = u; load = l; load_val = lv; sat_mode = s;
    @(posedge Clk);
    #1;
  endtask

  int wraps;
  logic [3:0] exp_c;

  initial begin
    // rst en up ld lv sat | count wrap tc
    add(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0);              // tc forced low during reset
    for (int i = 1; i <= 9; i++)
      add(0, 1, 1, 0, 4'd0, 0, 4'(i), 0, (i == 9));
    add(0, 1, 1, 0, 4'd0, 0, 4'd0, 1, 0);              // wrap 9 -> 0
    add(0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0);
    add(0, 1, 1, 0, 4'd0, 0, 4'd2, 0, 0);
    add(0, 1, 0, 1, 4'd0, 1, 4'd0, 0, 1);              // load 0, down
    add(0, 1, 0, 0, 4'd0, 1, 4'd0, 0, 1);              // saturate at 0
    add(0, 1, 0, 0, 4'd0, 1, 4'd0, 0, 1);
    add(0, 1, 0, 0, 4'd0, 1, 4'd0, 0, 1);
    add(0, 1, 0, 0, 4'd0, 0, 4'd9, 1, 0);              // wrap 0 -> 9
    add(0, 0, 0, 1, 4'd7, 0, 4'd7, 0, 0);              // load, en low
    add(0, 0, 1, 1, 4'd13, 0, 4'd9, 0, 1);             // clamp
    add(0, 0, 1, 1, 4'd10, 0, 4'd9, 0, 1);             // clamp at exact modulus
    add(0, 1, 1, 1, 4'd3, 0, 4'd3, 0, 0);              // load beats en
    add(0, 1, 0, 0, 4'd0, 0, 4'd2, 0, 0);
    add(0, 1, 0, 0, 4'd0, 0, 4'd1, 0, 0);
    add(0, 0, 1, 1, 4'd5, 0, 4'd5, 0, 0);
    add(1, 1, 1, 1, 4'd7, 0, 4'd0, 0, 0);              // reset beats load and en
    add(0, 1, 1, 0, 4'd0, 0, 4'd1, 0, 0);
    add(0, 0, 1, 1, 4'd4, 0, 4'd4, 0, 0);
    add(0, 1, 1, 0, 4'd0, 0, 4'd5, 0, 0);              // toggle direction
    add(0, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0);
    add(0, 1, 1, 0, 4'd0, 0, 4'd5, 0, 0);
    add(0, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0);
    add(0, 0, 1, 0, 4'd0, 0, 4'd4, 0, 0);              // idle holds
    add(0, 0, 0, 0, 4'd0, 0, 4'd4, 0, 0);
    add(0, 0, 1, 1, 4'd9, 1, 4'd9, 0, 1);
    add(0, 1, 1, 0, 4'd0, 1, 4'd9, 0, 1);              // saturate at top
    add(0, 1, 1, 0, 4'd0, 1, 4'd9, 0, 1);
    add(0, 1, 1, 0, 4'd0, 0, 4'd0, 1, 0);              // mode switch -> wrap
    add(0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0);              // pulse lasts one cycle

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv, vecs[i].sat);
      check($sformatf("count[%0d]", i), 32'(Count), 32'(vecs[i].exp_cnt));
      check($sformatf("wrap[%0d]", i), 32'(wrap_evt), 32'(vecs[i].exp_wrap));
      check($sformatf("tc[%0d]", i), 32'(tc), 32'(vecs[i].exp_tc));
    end

    // Free-running down count from 4 in wrap mode: wraps after step 5 and step 15
    drive(0, 0, 0, 1, 4'd4, 0);
    wraps = 0;
    exp_c = 4'd4;
    for (int k = 1; k <= 15; k++) begin
      drive(0, 1, 0, 0, 4'd0, 0);
      exp_c = (exp_c == 4'd0) ? 4'd9 : exp_c - 4'd1;
      check($sformatf("down_run[%0d]", k), 32'(Count), 32'(exp_c));
      if (wrap_evt) wraps++;
    end
    check("down_run_wraps", 32'(wraps), 32'd2);

`ifdef UPDOWN_CNT_OVF_STICKY_EN
    drive(1, 0, 1, 0, 4'd0, 0);
    check("ovf_reset", 32'(ovf_flag), 32'd0);
    drive(0, 0, 1, 1, 4'd9, 1);
    check("ovf_after_load", 32'(ovf_flag), 32'd0);
    drive(0, 1, 1, 0, 4'd0, 1);
    check("ovf_sat_set", 32'(ovf_flag), 32'd1);
    drive(0, 0, 1, 0, 4'd0, 1);
    check("ovf_sticky", 32'(ovf_flag), 32'd1);
    ovf_clr = 1'b1;
    drive(0, 0, 1, 0, 4'd0, 1);
    check("ovf_clear", 32'(ovf_flag), 32'd0);
    drive(0, 1, 1, 0, 4'd0, 0);
    check("ovf_set_wins", 32'(ovf_flag), 32'd1);
    check("ovf_set_wins_cnt", 32'(Count), 32'd0);
    ovf_clr = 1'b0;
    drive(1, 0, 1, 0, 4'd0, 0);
    check("ovf_reset_clear", 32'(ovf_flag), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised synchronous up/down counter. Successor to the fixed 4-bit up/down counter.
- Adds: configurable width and modulus, count enable, parallel load, runtime wrap/saturate mode, terminal-count and wrap-event outputs.
- Used as a general event or position counter feeding control FSMs. Single clock domain.

Parameters:
- WIDTH, 4, bit width of Count and load_val (2..32).
- MODULUS, 16, counting range is 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2^WIDTH.
- RESET_VAL, 0, value loaded on reset. Must be < MODULUS.

Ports:
- Clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- UpOrDown  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo MODULUS.
- Count  output  WIDTH  registered count.
- tc  output  1  combinational terminal count: Count is at the bound for the current direction.
- wrap_evt  output  1  registered one-cycle pulse: a wrap occurred on the previous edge.

Behaviour:
- All state updates on rising Clk. Priority order: reset > load > en. All inputs are sampled at the edge.
- Reset:
  - Count = RESET_VAL, wrap_evt = 0, optional ovf_flag = 0.
  - Reset asserted mid-count overrides load and en on that edge.
- Load:
  - Count = load_val if load_val < MODULUS, otherwise Count = MODULUS-1 (clamped).
  - wrap_evt = 0. Load takes effect even when en = 0.
- Count (en=1, load=0):
  - UpOrDown=1, Count < MODULUS-1: Count+1.
  - UpOrDown=1, Count = MODULUS-1: wrap mode gives 0 and wrap_evt=1 next cycle; saturate mode holds MODULUS-1 and wrap_evt=0.
  - UpOrDown=0, Count > 0: Count-1.
  - UpOrDown=0, Count = 0: wrap mode gives MODULUS-1 and wrap_evt=1; saturate mode holds 0.
- Idle (en=0, load=0): Count holds, wrap_evt=0.
- Arithmetic: no intermediate overflow when MODULUS = 2^WIDTH. Compare against the bound before incrementing or decrementing.
- tc:
  - Equals (UpOrDown ? Count==MODULUS-1 : Count==0), independent of en and sat_mode.
  - 0 while reset is asserted.
- Runtime changes: UpOrDown and sat_mode may change on any cycle. The new value applies at the next edge.
- Latency: 1 cycle from en/load/reset to Count. wrap_evt coincides with the wrapped Count value.

Optional Feature:
- Macro: UPDOWN_CNT_OVF_STICKY_EN.
- Defined:
  - Adds input ovf_clr (1 bit) and output ovf_flag (1 bit).
  - ovf_flag is set on any edge where a bound is hit with en=1 in either mode (wrap or saturate attempt).
  - ovf_flag stays set until ovf_clr=1 or reset.
  - If set and clear occur on the same edge, set wins.
- Undefined: neither port exists. No extra logic.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0):
- Reset then en=1, UpOrDown=1, sat_mode=0 for 12 cycles -> Count 1..9,0,1,2. wrap_evt high only in the cycle Count=0 after 9. tc=1 while Count=9.
- Count=0, UpOrDown=0, en=1, sat_mode=1 for 3 cycles -> Count holds 0, tc=1, wrap_evt=0. Switch sat_mode=0 -> Count=9, wrap_evt=1.
- load=1, load_val=7, en=0 -> Count=7 next cycle. load_val=13 -> Count=9 (clamp). load and en both high with UpOrDown=1 -> load value wins.
- Count=5, en=1, reset=1 pulsed for 1 cycle together with load=1 -> Count=0, wrap_evt=0. Counting resumes from 0 the following cycle.
- Toggle UpOrDown every cycle from Count=4 with en=1 -> Count 5,4,5,4. en=0 for 2 cycles -> Count holds.
- With UPDOWN_CNT_OVF_STICKY_EN: saturate at 9 going up -> ovf_flag=1 and stays 1. ovf_clr=1 -> ovf_flag=0. ovf_clr asserted on the same edge as a wrap -> ovf_flag=1.
